// File: rtl/div_defs.sv
// Shared definitions for the sequential signed divider: datapath width,
// FSM encoding and the saturation values driven on quotient overflow.
package div_defs;
  localparam int BIT = 16;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [BIT-1:0] SAT_POS = {1'b0, {(BIT-1){1'b1}}};
  localparam logic [BIT-1:0] SAT_NEG = {1'b1, {(BIT-1){1'b0}}};
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor if it fits, emit the quotient bit.
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);
  logic [W:0] trial;

  // rem_in < dvs always holds, so the trial value is below 2*dvs and the
  // difference fits in W bits; the subtraction can be done modulo 2^W.
  always_comb begin
    trial   = {rem_in, bit_in};
    q_bit   = (trial >= {1'b0, dvs});
    rem_out = q_bit ? (trial[W-1:0] - dvs) : trial[W-1:0];
  end
endmodule

// File: rtl/divider_seq.sv
// Sequential signed divider (2*BIT / BIT): sign-magnitude front end, BIT-cycle
// restoring core, sign fix-up with saturation and divide-by-zero reporting.
module divider_seq #(
  parameter int BIT = div_defs::BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*BIT-1:0] dividend,
  input  logic [BIT-1:0]   divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIT-1:0]   quotient,
  output logic [BIT-1:0]   remainder,
  output logic             ovf,
  output logic             dbz
);
  import div_defs::state_t;
  import div_defs::IDLE;
  import div_defs::CALC;
  import div_defs::FIX;
  import div_defs::DONE;
  import div_defs::SAT_POS;
  import div_defs::SAT_NEG;

  localparam int CW = (BIT > 1) ? $clog2(BIT) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIT-1:0]   rem_q, rem_d;
  logic [BIT-1:0]   lo_q, lo_d;
  logic [BIT-1:0]   dvs_q, dvs_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic             pre_q, pre_d;
  logic             zero_q, zero_d;
  logic [BIT-1:0]   quo_q, quo_d;
  logic [BIT-1:0]   rmd_q, rmd_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [2*BIT-1:0] abs_dvd;
  logic [BIT-1:0]   abs_dvs;
  logic [BIT-1:0]   step_rem;
  logic             step_q;
  logic             post_ovf;

  // Magnitudes are unsigned, so the most negative inputs map to 2^(N-1) exactly.
  assign abs_dvd = dividend[2*BIT-1] ? (~dividend + 1'b1) : dividend;
  assign abs_dvs = divisor[BIT-1]    ? (~divisor + 1'b1)  : divisor;

  // lo_q shifts dividend bits out of its MSB while quotient bits enter its LSB.
  div_step #(.W(BIT)) u_step (
    .rem_in  (rem_q),
    .bit_in  (lo_q[BIT-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // A negative result may reach one more magnitude step than a positive one.
  assign post_ovf = sq_q ? (lo_q > SAT_NEG) : (lo_q > SAT_POS);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    pre_d   = pre_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d  = abs_dvs;
          rem_d  = abs_dvd[2*BIT-1:BIT];
          lo_d   = abs_dvd[BIT-1:0];
          sq_d   = dividend[2*BIT-1] ^ divisor[BIT-1];
          sr_d   = dividend[2*BIT-1];
          cnt_d  = '0;
          zero_d = (divisor == '0);
          pre_d  = (divisor != '0) && (abs_dvd[2*BIT-1:BIT] >= abs_dvs);
          // The divide-by-zero result reports the raw low dividend bits.
          if (divisor == '0) rem_d = dividend[BIT-1:0];
          state_d = ((divisor == '0) || (abs_dvd[2*BIT-1:BIT] >= abs_dvs)) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        lo_d  = {lo_q[BIT-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BIT-1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        if (zero_q) begin
          quo_d = '0;
          rmd_d = rem_q;
          ovf_d = 1'b0;
          dbz_d = 1'b1;
        end else if (pre_q || post_ovf) begin
          quo_d = sq_q ? SAT_NEG : SAT_POS;
          rmd_d = '0;
          ovf_d = 1'b1;
          dbz_d = 1'b0;
        end else begin
          quo_d = sq_q ? (~lo_q + 1'b1) : lo_q;
          rmd_d = sr_q ? (~rem_q + 1'b1) : rem_q;
          ovf_d = 1'b0;
          dbz_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      pre_q   <= 1'b0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      pre_q   <= pre_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end
endmodule
